// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: walks a KH x KW convolution window through the pixel
// and weight memories and feeds one registered operand pair per cycle to a
// free-running Q8.8 MAC. It clears the MAC before the job and captures the
// accumulated result at the end.
//
// Handshake: start is a single-cycle request that is sampled only in IDLE.
// busy is high from acceptance until done. done is a one-cycle pulse, and
// result_out is valid from that cycle until the next capture. mem_rd_en
// qualifies both memory addresses, and read data returns one cycle later.
module mac_operand_sequencer #(
  parameter int KW     = 3,
  parameter int KH     = 3,
  parameter int IMG_W  = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pixel_base,
  input  logic [ADDR_W-1:0] weight_base,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] pixel_rdata,
  input  logic [DATA_W-1:0] weight_rdata,
  output logic [DATA_W-1:0] mac_pixel,
  output logic [DATA_W-1:0] mac_weight,
  output logic              mac_clear,
  input  logic [DATA_W-1:0] mac_result,
  output logic [DATA_W-1:0] result_out,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam int T     = KW * KH;
  localparam int CNT_W = $clog2(T + 1);
  localparam int COL_W = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tap_cnt;
  logic [COL_W-1:0]   col_cnt;
  logic [ADDR_W-1:0]  row_base;
  logic               addr_load;
  logic               addr_step;
  logic               capture;

  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d   = state_q;
    mac_clear = 1'b0;
    mem_rd_en = 1'b0;
    addr_load = 1'b0;
    addr_step = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_load = 1'b1;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        // Tap 0 is read here while the MAC is zeroed.
        mac_clear = 1'b1;
        mem_rd_en = 1'b1;
        addr_step = (T > 1);
        state_d   = STREAM;
      end
      STREAM: begin
        // In tap k, the address of tap k+1 is presented, and the pointer
        // moves to tap k+2 at the end of the cycle.
        mem_rd_en = (int'(tap_cnt) + 1 < T);
        addr_step = (int'(tap_cnt) + 2 < T);
        if (int'(tap_cnt) == T - 1) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tap counter: zeroed during CLEAR and stepped once per STREAM cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  tap_cnt <= '0;
    else if (state_q == CLEAR)   tap_cnt <= '0;
    else if (state_q == STREAM)  tap_cnt <= tap_cnt + CNT_W'(1);
  end

  // Address generator: column fastest, row pitch IMG_W, modulo 2^ADDR_W.
  // The address holds when no read is pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_addr  <= '0;
      weight_addr <= '0;
      row_base    <= '0;
      col_cnt     <= '0;
    end else if (addr_load) begin
      pixel_addr  <= pixel_base;
      weight_addr <= weight_base;
      row_base    <= pixel_base;
      col_cnt     <= '0;
    end else if (addr_step) begin
      weight_addr <= weight_addr + ADDR_W'(1);
      if (int'(col_cnt) == KW - 1) begin
        col_cnt    <= '0;
        row_base   <= row_base + ADDR_W'(IMG_W);
        pixel_addr <= row_base + ADDR_W'(IMG_W);
      end else begin
        col_cnt    <= col_cnt + COL_W'(1);
        pixel_addr <= pixel_addr + ADDR_W'(1);
      end
    end
  end

  // Operand registers carry tap data only for the T streamed taps. At all
  // other times they are zero, so the free-running accumulator holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_pixel  <= '0;
      mac_weight <= '0;
    end else if (state_q == STREAM) begin
      mac_pixel  <= pixel_rdata;
      mac_weight <= weight_rdata;
    end else begin
      mac_pixel  <= '0;
      mac_weight <= '0;
    end
  end

  // Job status and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      result_out <= '0;
    end else begin
      done <= capture;
      if (addr_load)    busy <= 1'b1;
      else if (capture) busy <= 1'b0;
      if (capture) result_out <= mac_result;
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed testbench for mac_operand_sequencer. It uses a 1-cycle-latency
// memory model and a behavioural Q8.8 MAC (sum += (p*w)[23:8]).
module tb_mac_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pixel_base;
  logic [7:0]  weight_base;
  logic [7:0]  pixel_addr;
  logic [7:0]  weight_addr;
  logic        mem_rd_en;
  logic [15:0] pixel_rdata = '0;
  logic [15:0] weight_rdata = '0;
  logic [15:0] mac_pixel;
  logic [15:0] mac_weight;
  logic        mac_clear;
  logic [15:0] mac_result = '0;
  logic [15:0] result_out;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  mac_operand_sequencer #(
    .KW(3), .KH(3), .IMG_W(8), .ADDR_W(8), .DATA_W(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pixel_base   (pixel_base),
    .weight_base  (weight_base),
    .pixel_addr   (pixel_addr),
    .weight_addr  (weight_addr),
    .mem_rd_en    (mem_rd_en),
    .pixel_rdata  (pixel_rdata),
    .weight_rdata (weight_rdata),
    .mac_pixel    (mac_pixel),
    .mac_weight   (mac_weight),
    .mac_clear    (mac_clear),
    .mac_result   (mac_result),
    .result_out   (result_out),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // Memories: pixels are all 0x0100. Weights are 0x0200 below 0x80 and
  // 0x0100 from 0x80 upward.
  logic [15:0] pmem [256];
  logic [15:0] wmem [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      pmem[i] = 16'h0100;
      wmem[i] = (i < 128) ? 16'h0200 : 16'h0100;
    end
  end

  // Memory read port with 1-cycle latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      pixel_rdata  <= pmem[pixel_addr];
      weight_rdata <= wmem[weight_addr];
    end
  end

  // Behavioural free-running MAC.
  logic [31:0] prod;
  assign prod = mac_pixel * mac_weight;
  always @(posedge clk) begin
    if (mac_clear) mac_result <= '0;
    else           mac_result <= mac_result + prod[23:8];
  end

  // Monitors: observed read addresses, clear pulses and done pulses.
  logic [7:0] pa_q [$];
  logic [7:0] wa_q [$];
  int clr_cnt  = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (mem_rd_en) begin
      pa_q.push_back(pixel_addr);
      wa_q.push_back(weight_addr);
    end
    if (mac_clear) clr_cnt++;
    if (done)      done_cnt++;
  end

  // Scoreboard expected queues.
  logic [7:0] exp_q  [$];
  logic [7:0] expw_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: launch a job from a negedge and wait for done.
  // lat counts rising edges after the start-sampling edge until done is visible.
  // mid_at >= 0 raises start for one cycle at that point in the job.
  // hold_at_done leaves start high in the done cycle.
  task automatic run_job(input logic [7:0] pb, input logic [7:0] wb, input int mid_at,
                         input bit hold_at_done, output int lat, output int busy_cnt);
    pixel_base  = pb;
    weight_base = wb;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (lat < 40) begin
      if (busy) busy_cnt++;
      if (done) break;
      start = (lat == mid_at);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = hold_at_done;
  endtask

  // Drain the address queues captured since 'from' and compare against the expected queues.
  task automatic check_addrs(input string tag, input int from_p);
    check({tag, "_rd_count"}, pa_q.size() - from_p, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (from_p + i < pa_q.size()) begin
        check($sformatf("%s_pix%0d", tag, i), pa_q[from_p + i], exp_q[i]);
        check($sformatf("%s_wgt%0d", tag, i), wa_q[from_p + i], expw_q[i]);
      end
    end
  endtask

  int lat, bc, c0, d0, p0, viol_op, viol_rd, viol_res;
  logic [15:0] held;
  logic [7:0] pix_a [9];
  logic [7:0] pix_b [9];

  initial begin
    pix_a = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A, 8'h20, 8'h21, 8'h22};
    pix_b = '{8'hFE, 8'hFF, 8'h00, 8'h06, 8'h07, 8'h08, 8'h0E, 8'h0F, 8'h10};
    reset = 1'b0;
    start = 1'b0;
    pixel_base = '0;
    weight_base = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_clear", mac_clear, 0);
    check("rst_mac_pixel", mac_pixel, 0);
    check("rst_mac_weight", mac_weight, 0);
    check("rst_result", result_out, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic job: 9 * (0x100 * 0x200 >> 8) = 0x1200
    c0 = clr_cnt;
    run_job(8'h00, 8'h00, -1, 1'b0, lat, bc);
    check("job_basic_latency", lat, 12);
    check("job_basic_busy_cycles", bc, 12);
    check("job_basic_result", result_out, 16'h1200);
    check("job_basic_clear_pulses", clr_cnt - c0, 1);
    check("job_basic_busy_in_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("result_holds", result_out, 16'h1200);

    // Address sequence with row pitch
    exp_q.delete();
    expw_q.delete();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(pix_a[i]);
      expw_q.push_back(8'h40 + 8'(i));
    end
    p0 = pa_q.size();
    run_job(8'h10, 8'h40, -1, 1'b0, lat, bc);
    @(negedge clk);
    check_addrs("addr_seq", p0);
    check("addr_seq_result", result_out, 16'h1200);

    // Pixel address wrap
    exp_q.delete();
    expw_q.delete();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(pix_b[i]);
      expw_q.push_back(8'h00 + 8'(i));
    end
    p0 = pa_q.size();
    run_job(8'hFE, 8'h00, -1, 1'b0, lat, bc);
    @(negedge clk);
    check_addrs("addr_wrap", p0);

    // Mid-job start ignored; start held in the done cycle launches job 2
    c0 = clr_cnt;
    run_job(8'h00, 8'h00, 5, 1'b1, lat, bc);
    check("b2b_job1_latency", lat, 12);
    check("b2b_job1_result", result_out, 16'h1200);
    check("b2b_job1_clear_pulses", clr_cnt - c0, 1);
    c0 = clr_cnt;
    run_job(8'h00, 8'h80, -1, 1'b0, lat, bc);
    check("b2b_job2_latency", lat, 12);
    check("b2b_job2_result", result_out, 16'h0900);
    check("b2b_job2_clear_pulses", clr_cnt - c0, 1);
    @(negedge clk);

    // Reset during STREAM tap 4
    pixel_base = 8'h00;
    weight_base = 8'h00;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_abort_state", dbg_state, 2);
    check("pre_abort_busy", busy, 1);
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_clear", mac_clear, 0);
    check("abort_mac_pixel", mac_pixel, 0);
    check("abort_mac_weight", mac_weight, 0);
    check("abort_result", result_out, 0);
    check("abort_addr", {pixel_addr, weight_addr}, 0);
    check("abort_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_job(8'h00, 8'h00, -1, 1'b0, lat, bc);
    check("post_abort_latency", lat, 12);
    check("post_abort_result", result_out, 16'h1200);

    // Idle for 20 cycles after done: operands zero, no reads, accumulator steady
    held = mac_result;
    viol_op = 0;
    viol_rd = 0;
    viol_res = 0;
    repeat (20) begin
      @(negedge clk);
      if (mac_pixel !== 16'h0 || mac_weight !== 16'h0) viol_op++;
      if (mem_rd_en !== 1'b0) viol_rd++;
      if (mac_result !== held) viol_res++;
    end
    check("idle_operands_zero", viol_op, 0);
    check("idle_no_reads", viol_rd, 0);
    check("idle_mac_steady", viol_res, 0);
    check("idle_mac_value", held, 16'h1200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit for the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
